// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both
// sides and an XOR checksum accumulator driven by the XACC operation.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_XNOR  = 3'b100,
    OP_ANDN  = 3'b101,
    OP_XACC  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  op_e              op1;

  logic             s1_adv;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] result;

  // Stage 1 may hand over when stage 2 is empty or is being drained this cycle.
  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && s1_adv;
  assign out_valid = s2_valid;

  // A clear on the same edge as an XACC transfer applies before the XOR.
  assign acc_base = acc_clr ? '0 : acc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    unique case (op1)
      OP_AND:   result = a1 & b1;
      OP_OR:    result = a1 | b1;
      OP_XOR:   result = a1 ^ b1;
      OP_NOR:   result = ~(a1 | b1);
      OP_XNOR:  result = ~(a1 ^ b1);
      OP_ANDN:  result = a1 & ~b1;
      OP_XACC:  result = acc_base ^ a1 ^ b1;
      OP_PASSA: result = a1;
      default:  result = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      // NOTE: data registers are reset too, so nothing stale is observable after reset.
      a1       <= '0;
      b1       <= '0;
      op1      <= OP_AND;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      a1       <= A;
      b1       <= B;
      op1      <= op_e'(op);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      res      <= '0;
      zero     <= 1'b0;
      parity   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      res      <= result;
      zero     <= (result == '0);
      parity   <= ^result;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (s2_load && op1 == OP_XACC) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table, streaming with
// backpressure, randomized traffic against a queue model, reset and 8-bit cases.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, acc_clr, out_valid, out_ready, zero, parity;
  logic [31:0] a, b, res, acc;
  logic [2:0]  op;

  logic        in_valid8, in_ready8, acc_clr8, out_valid8, out_ready8, zero8, parity8;
  logic [7:0]  a8, b8, res8, acc8;
  logic [2:0]  op8;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] acc_m;
  logic [31:0] stall_res;
  logic        stalled;
  logic        accepted;

  typedef struct {
    logic        clr;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        par;
    logic [31:0] acc;
  } vec_t;

  vec_t tbl[16];

  logic_unit_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .zero(zero), .parity(parity), .acc(acc)
  );

  logic_unit_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .op(op8), .acc_clr(acc_clr8), .out_valid(out_valid8),
    .out_ready(out_ready8), .res(res8), .zero(zero8), .parity(parity8), .acc(acc8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single isolated beat: accepted at edge N, checked just after edge N+1.
  task automatic send_beat(input vec_t t, input string tag);
    a = t.a; b = t.b; op = t.op; in_valid = 1'b1; out_ready = 1'b1; acc_clr = 1'b0;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    acc_clr  = t.clr;
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    acc_clr = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, res, t.res);
    check({tag, "_zero"}, 32'(zero), 32'(t.zero));
    check({tag, "_parity"}, 32'(parity), 32'(t.par));
    check({tag, "_acc"}, acc, t.acc);
  endtask

  task automatic send8(input logic clr, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [2:0] top, input logic [7:0] eres, input logic ezero,
                       input logic epar, input logic [7:0] eacc, input string tag);
    a8 = ta; b8 = tb_; op8 = top; in_valid8 = 1'b1; out_ready8 = 1'b1; acc_clr8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    acc_clr8  = clr;
    tick();
    acc_clr8 = 1'b0;
    check({tag, "_valid"}, 32'(out_valid8), 32'd1);
    check({tag, "_res"}, 32'(res8), 32'(eres));
    check({tag, "_zero"}, 32'(zero8), 32'(ezero));
    check({tag, "_parity"}, 32'(parity8), 32'(epar));
    check({tag, "_acc"}, 32'(acc8), 32'(eacc));
  endtask

  // One clock of scoreboarded traffic: inputs are already driven; observe at negedge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (stalled) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_res", res, stall_res);
    end
    check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !out_ready)));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out got=%h required=no_beat", res);
      end else begin
        e = exp_q.pop_front();
        check("sb_res", res, e);
        check("sb_zero", 32'(zero), 32'(e == 32'd0));
        check("sb_parity", 32'(parity), 32'(^e));
        got_q.push_back(res);
      end
    end
    stalled   = out_valid && !out_ready;
    stall_res = res;
    accepted  = in_valid && in_ready;
    if (accepted) begin
      case (op)
        3'd0: e = a & b;
        3'd1: e = a | b;
        3'd2: e = a ^ b;
        3'd3: e = ~(a | b);
        3'd4: e = ~(a ^ b);
        3'd5: e = a & ~b;
        3'd6: begin acc_m = acc_m ^ a ^ b; e = acc_m; end
        default: e = a;
      endcase
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] s_a[4]   = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
  logic [31:0] s_b[4]   = '{32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF};
  logic [2:0]  s_op[4]  = '{3'd0, 3'd1, 3'd3, 3'd4};
  logic [31:0] s_exp[4] = '{32'h000F000F, 32'h0FFF0FFF, 32'hF000F000, 32'hF00FF00F};

  initial begin
    tbl[0]  = '{1'b0, 32'h0000FFFF, 32'h00FF00FF, 3'd2, 32'h00FFFF00, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'hFFFF0000, 32'h0000FFFF, 3'd0, 32'h00000000, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 3'd0, 32'h000F000F, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 3'd1, 32'h0FFF0FFF, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 3'd3, 32'hF000F000, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 3'd4, 32'hF00FF00F, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000000F, 32'h00000001, 3'd5, 32'h0000000E, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h80000000, 32'h12345678, 3'd7, 32'h80000000, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'h00000001, 32'h00000002, 3'd6, 32'h00000003, 1'b0, 1'b0, 32'h3};
    tbl[9]  = '{1'b0, 32'h00000004, 32'h00000000, 3'd6, 32'h00000007, 1'b0, 1'b1, 32'h7};
    tbl[10] = '{1'b0, 32'h000000FF, 32'h00000000, 3'd6, 32'h000000F8, 1'b0, 1'b1, 32'hF8};
    tbl[11] = '{1'b0, 32'h000000FF, 32'h0000000F, 3'd5, 32'h000000F0, 1'b0, 1'b0, 32'hF8};
    tbl[12] = '{1'b1, 32'h00000010, 32'h00000001, 3'd6, 32'h00000011, 1'b0, 1'b0, 32'h11};
    tbl[13] = '{1'b0, 32'h00000005, 32'h00000000, 3'd6, 32'h00000014, 1'b0, 1'b0, 32'h14};
    tbl[14] = '{1'b1, 32'h00000003, 32'h00000000, 3'd1, 32'h00000003, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 32'h00000022, 32'h00000000, 3'd6, 32'h00000022, 1'b0, 1'b0, 32'h22};

    a = '0; b = '0; op = '0; acc_clr = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    a8 = '0; b8 = '0; op8 = '0; acc_clr8 = 1'b0; out_ready8 = 1'b1; in_valid8 = 1'b0;
    stalled = 1'b0; stall_res = '0; acc_m = '0; accepted = 1'b0;

    // Reset held with a beat offered.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_acc", acc, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // Single-beat vectors: latency, every op, accumulator chain and clears.
    for (int i = 0; i < 16; i++) send_beat(tbl[i], $sformatf("v%0d", i));
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("clr_alone_acc", acc, 32'd0);
    tick();

    // Back-to-back stream with a three-cycle sink stall.
    exp_q.delete(); got_q.delete(); acc_m = '0; stalled = 1'b0;
    begin
      int bi = 0;
      int c  = 0;
      while (got_q.size() < 4 && c < 40) begin
        in_valid  = (bi < 4);
        if (bi < 4) begin a = s_a[bi]; b = s_b[bi]; op = s_op[bi]; end
        out_ready = !(c >= 2 && c <= 4);
        step();
        if (accepted) bi++;
        c++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("stream_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check($sformatf("stream_res%0d", i), got_q[i], s_exp[i]);

    // Randomized traffic against the queue model (accumulator starts at 0).
    acc_m = acc;
    check("rand_acc_start", acc, 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand");
    check("rand_acc_end", acc, acc_m);

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 32'h1; b = 32'h2; op = 3'd1;
    tick();
    a = 32'h4; op = 3'd6;
    tick();
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 32'd1);
    check("inflight_full", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_res", res, 32'd0);
    check("async_rst_acc", acc, 32'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_beat", 32'(out_valid), 32'd0);
    end
    send_beat(tbl[0], "post_rst");
    tick();

    // Narrow instance.
    send8(1'b0, 8'h0F, 8'hFF, 3'd2, 8'hF0, 1'b0, 1'b0, 8'h00, "w8_xor");
    send8(1'b0, 8'h0F, 8'hF0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, "w8_and");
    send8(1'b0, 8'h80, 8'h00, 3'd7, 8'h80, 1'b0, 1'b1, 8'h00, "w8_passa");
    send8(1'b0, 8'h01, 8'h02, 3'd6, 8'h03, 1'b0, 1'b0, 8'h03, "w8_xacc");
    send8(1'b1, 8'h10, 8'h01, 3'd6, 8'h11, 1'b0, 1'b0, 8'h11, "w8_xacc_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
